dff_pipe_sr: RTL and testbench



---
 rtl/dff_pipe_sr.sv | 83 ++++++++
 tb/tb_dff_pipe_sr.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dff_pipe_sr.sv
// W-bit, DEPTH-stage registered delay line with per-stage valid bits, stall,
// flush and a live count of occupied stages. All outputs come straight from flops.
module dff_pipe_sr #(
   parameter int           W       = 8,
   parameter int           DEPTH   = 3,
   parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       EN,
   input  logic                       FLUSH,
   input  logic [W-1:0]               D,
   input  logic                       D_VALID,
   output logic [W-1:0]               Q,
   output logic                       Q_VALID,
   output logic [$clog2(DEPTH+1)-1:0] COUNT
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   generate
      if (DEPTH < 1) begin : g_bad_depth
         $error("dff_pipe_sr: DEPTH must be at least 1");
      end
   endgenerate

   logic [W-1:0]     data_q [DEPTH];
   logic [W-1:0]     data_d [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;

   // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      cnt_d  = cnt_q;
      if (FLUSH) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = RST_VAL;
         end
         vld_d = '0;
         cnt_d = '0;
      end else if (EN) begin
         data_d[0] = D;
         vld_d[0]  = D_VALID;
         for (int i = 1; i < DEPTH; i++) begin
            data_d[i] = data_q[i-1];
            vld_d[i]  = vld_q[i-1];
         end
         // One entry may enter and one may leave on the same edge.
         cnt_d = cnt_q + CW'(D_VALID) - CW'(vld_q[DEPTH-1]);
      end
   end

   // NOTE: the data stages are reset too, so Q shows RST_VAL rather than X after reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= RST_VAL;
         end
         vld_q <= '0;
         cnt_q <= '0;
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
         cnt_q  <= cnt_d;
      end
   end

   assign Q       = data_q[DEPTH-1];
   assign Q_VALID = vld_q[DEPTH-1];
   assign COUNT   = cnt_q;

   a_count_bounded : assert property (@(posedge CLK) disable iff (!RST_N)
      (cnt_q <= DEPTH_C) && (cnt_q == CW'($countones(vld_q))));

   a_ctrl_known : assert property (@(posedge CLK)
      RST_N |-> !$isunknown({EN, FLUSH, D_VALID}));

endmodule

// File: tb/tb_dff_pipe_sr.sv
// Bench for dff_pipe_sr: a table of hand-derived vectors, hand-written stall and
// reset sequences, and a due-edge scoreboard that follows every edge including random traffic.
module tb_dff_pipe_sr;

   localparam int          W       = 8;
   localparam int          DEPTH   = 3;
   localparam logic [W-1:0] RST_VAL = 8'hA5;

   logic         CLK = 1'b0;
   logic         RST_N = 1'b0;
   logic         EN = 1'b0;
   logic         FLUSH = 1'b0;
   logic [W-1:0] D = '0;
   logic         D_VALID = 1'b0;
   logic [W-1:0] Q;
   logic         Q_VALID;
   logic [1:0]   COUNT;

   dff_pipe_sr #(.W(W), .DEPTH(DEPTH), .RST_VAL(RST_VAL)) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .EN      (EN),
      .FLUSH   (FLUSH),
      .D       (D),
      .D_VALID (D_VALID),
      .Q       (Q),
      .Q_VALID (Q_VALID),
      .COUNT   (COUNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic         rst_n;
      logic         en;
      logic         flush;
      logic [W-1:0] d;
      logic         dv;
      logic [W-1:0] q;
      logic         qv;
      logic [1:0]   cnt;
   } vec_t;

   typedef struct {
      logic [W-1:0] data;
      int           due;
   } sb_item_t;

   int       total = 0;
   int       bad   = 0;
   int       en_edges = 0;
   sb_item_t sb[$];
   vec_t     vecs[21];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one edge's inputs, predict in the scoreboard, clock, then compare.
   // A sample captured on enabled edge e is due on Q after enabled edge e+DEPTH-1.
   task automatic apply(input logic rst_n, input logic en, input logic flush,
                        input logic [W-1:0] d, input logic dv);
      logic exp_qv;
      RST_N   = rst_n;
      EN      = en;
      FLUSH   = flush;
      D       = d;
      D_VALID = dv;
      if (!rst_n || flush) begin
         sb.delete();
      end else if (en) begin
         en_edges++;
         if (dv) sb.push_back('{data: d, due: en_edges + DEPTH - 1});
      end
      @(posedge CLK);
      #1;
      while (sb.size() > 0 && sb[0].due < en_edges) void'(sb.pop_front());
      exp_qv = (sb.size() > 0) && (sb[0].due == en_edges);
      check("sb_qvalid", 32'(Q_VALID), 32'(exp_qv));
      check("sb_count", 32'(COUNT), 32'(sb.size()));
      if (exp_qv) check("sb_q", 32'(Q), 32'(sb[0].data));
   endtask

   task automatic expect_out(input string name, input logic [W-1:0] q,
                             input logic qv, input logic [1:0] cnt);
      check({name, "_q"}, 32'(Q), 32'(q));
      check({name, "_qv"}, 32'(Q_VALID), 32'(qv));
      check({name, "_cnt"}, 32'(COUNT), 32'(cnt));
   endtask

   initial begin
      //            rst   en    flush d      dv    q      qv    cnt
      // reset held with junk on the other inputs
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 8'hA5, 1'b0, 2'd0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 8'hA5, 1'b0, 2'd0};
      // streaming 11, 22, 33, 44 then drain
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 8'hA5, 1'b0, 2'd1};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h22, 1'b1, 8'hA5, 1'b0, 2'd2};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h33, 1'b1, 8'h11, 1'b1, 2'd3};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h44, 1'b1, 8'h22, 1'b1, 2'd3};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h33, 1'b1, 2'd2};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h44, 1'b1, 2'd1};
      // fill three valid entries, then flush with 77 presented
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 8'h00, 1'b0, 2'd1};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h66, 1'b1, 8'h00, 1'b0, 2'd2};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h67, 1'b1, 8'h55, 1'b1, 2'd3};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 8'hA5, 1'b0, 2'd0};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 2'd0};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 2'd0};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0};
      // bubbles: data flows even when not valid
      vecs[15] = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 8'h00, 1'b0, 2'd1};
      vecs[16] = '{1'b1, 1'b1, 1'b0, 8'h02, 1'b0, 8'h00, 1'b0, 2'd1};
      vecs[17] = '{1'b1, 1'b1, 1'b0, 8'h03, 1'b1, 8'h01, 1'b1, 2'd2};
      vecs[18] = '{1'b1, 1'b1, 1'b0, 8'h04, 1'b0, 8'h02, 1'b0, 2'd1};
      vecs[19] = '{1'b1, 1'b1, 1'b0, 8'h05, 1'b1, 8'h03, 1'b1, 2'd2};
      vecs[20] = '{1'b1, 1'b1, 1'b0, 8'h06, 1'b0, 8'h04, 1'b0, 2'd1};

      #2;
      for (int i = 0; i < 21; i++) begin
         apply(vecs[i].rst_n, vecs[i].en, vecs[i].flush, vecs[i].d, vecs[i].dv);
         expect_out($sformatf("vec%0d", i), vecs[i].q, vecs[i].qv, vecs[i].cnt);
      end

      // Stall: load 11 and 22, freeze for four edges with toggling data, resume.
      apply(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
      expect_out("stall_flush", 8'hA5, 1'b0, 2'd0);
      apply(1'b1, 1'b1, 1'b0, 8'h11, 1'b1);
      apply(1'b1, 1'b1, 1'b0, 8'h22, 1'b1);
      expect_out("stall_load", 8'hA5, 1'b0, 2'd2);
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, 1'b0, 1'b0, (i % 2 == 0) ? 8'hFF : 8'h00, 1'b1);
         expect_out($sformatf("stall_hold%0d", i), 8'hA5, 1'b0, 2'd2);
      end
      apply(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      expect_out("stall_resume0", 8'h11, 1'b1, 2'd2);
      apply(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      expect_out("stall_resume1", 8'h22, 1'b1, 2'd1);
      apply(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      expect_out("stall_resume2", 8'h00, 1'b0, 2'd0);

      // Reset pulse mid-stream, then first post-reset sample arrives three edges later.
      apply(1'b1, 1'b1, 1'b0, 8'h81, 1'b1);
      apply(1'b1, 1'b1, 1'b0, 8'h82, 1'b1);
      apply(1'b1, 1'b1, 1'b0, 8'h83, 1'b1);
      expect_out("mid_full", 8'h81, 1'b1, 2'd3);
      apply(1'b0, 1'b1, 1'b0, 8'h84, 1'b1);
      expect_out("mid_rst", 8'hA5, 1'b0, 2'd0);
      apply(1'b1, 1'b1, 1'b0, 8'h90, 1'b1);
      expect_out("mid_rel1", 8'hA5, 1'b0, 2'd1);
      apply(1'b1, 1'b1, 1'b0, 8'h91, 1'b1);
      expect_out("mid_rel2", 8'hA5, 1'b0, 2'd2);
      apply(1'b1, 1'b1, 1'b0, 8'h92, 1'b1);
      expect_out("mid_rel3", 8'h90, 1'b1, 2'd3);

      // Random traffic, checked by the scoreboard alone.
      for (int i = 0; i < 400; i++) begin
         apply(($urandom_range(0, 59) != 0),
               ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 39) == 0),
               8'($urandom()),
               1'($urandom()));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
